// File: rtl/mem_wb_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe_pkg
// Description : Shared MEM/WB payload struct and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_REG_W  = 5;
  localparam int DEFAULT_CNT_W  = 16;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] read_data;
    logic [DEFAULT_DATA_W-1:0] alu_result;
    logic [DEFAULT_REG_W-1:0]  write_reg;
    logic                      reg_write;
    logic                      mem_to_reg;
  } mem_wb_payload_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe_if
// Description : MEM-side handshake and WB-side outputs of the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_pipe_if
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_W  = DEFAULT_REG_W,
  parameter int CNT_W  = DEFAULT_CNT_W
);
  logic              mem_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_ReadData;
  logic [DATA_W-1:0] mem_AluResult;
  logic [REG_W-1:0]  mem_WriteReg;
  logic              mem_RegWrite;
  logic              mem_MemtoReg;
  logic              flush;
  logic              wb_stall;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_ReadData;
  logic [DATA_W-1:0] wb_AluResult;
  logic [REG_W-1:0]  wb_WriteReg;
  logic              wb_RegWrite;
  logic [DATA_W-1:0] wb_WriteData;
  logic [CNT_W-1:0]  wb_retired;

  modport master (
    output mem_valid, mem_ReadData, mem_AluResult, mem_WriteReg, mem_RegWrite,
           mem_MemtoReg, flush, wb_stall,
    input  mem_ready, wb_valid, wb_ReadData, wb_AluResult, wb_WriteReg,
           wb_RegWrite, wb_WriteData, wb_retired
  );

  modport slave (
    input  mem_valid, mem_ReadData, mem_AluResult, mem_WriteReg, mem_RegWrite,
           mem_MemtoReg, flush, wb_stall,
    output mem_ready, wb_valid, wb_ReadData, wb_AluResult, wb_WriteReg,
           wb_RegWrite, wb_WriteData, wb_retired
  );

endinterface
`default_nettype wire

// File: rtl/mem_wb_pipe_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid
// Description : One-entry skid buffer; ready is a register meaning "empty".
//               Compiled only when MEM_WB_SKID_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef MEM_WB_SKID_EN
module pipe_skid
  import mem_wb_pipe_pkg::*;
#(
  parameter type T = mem_wb_payload_t
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  T     in_data,
  output logic out_valid,
  output T     out_data,
  output logic ready
);
  logic skid_valid_q, skid_valid_d;
  logic ready_q, ready_d;
  T     skid_data_q, skid_data_d;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (reset) begin
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (flush) begin
      skid_valid_d = 1'b0;
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end else if (pop) begin
      skid_valid_d = 1'b0;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    skid_valid_q <= skid_valid_d;
    skid_data_q  <= skid_data_d;
    ready_q      <= ready_d;
  end

  assign out_valid = skid_valid_q;
  assign out_data  = skid_data_q;
  assign ready     = ready_q;

endmodule
`endif
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe
// Description : MEM/WB pipeline register with valid/ready handshake, flush,
//               retire counter. Optional skid buffer: MEM_WB_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_W  = DEFAULT_REG_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  mem_wb_pipe_if.slave bus
);
  // Same layout as mem_wb_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_to_reg;
  } payload_t;

  payload_t         w_mem_payload;
  payload_t         w_skid_payload;
  payload_t         wb_data_q, wb_data_d;
  logic             wb_valid_q, wb_valid_d;
  logic [CNT_W-1:0] wb_retired_q, wb_retired_d;
  logic             w_accept, w_retire, w_push, w_pop;

  assign w_mem_payload = '{read_data:  bus.mem_ReadData,
                           alu_result: bus.mem_AluResult,
                           write_reg:  bus.mem_WriteReg,
                           reg_write:  bus.mem_RegWrite,
                           mem_to_reg: bus.mem_MemtoReg};

  assign w_accept = bus.mem_valid && bus.mem_ready;
  assign w_retire = wb_valid_q && !bus.wb_stall && !bus.flush;

`ifdef MEM_WB_SKID_EN
  logic w_skid_valid, w_skid_ready;

  // Accepts landing on a full, stalled output park in the skid entry.
  assign w_push = w_accept && wb_valid_q && bus.wb_stall;
  assign w_pop  = w_skid_valid && !bus.wb_stall && !bus.flush;

  pipe_skid #(.T(payload_t)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush),
    .push      (w_push),
    .pop       (w_pop),
    .in_data   (w_mem_payload),
    .out_valid (w_skid_valid),
    .out_data  (w_skid_payload),
    .ready     (w_skid_ready)
  );

  assign bus.mem_ready = w_skid_ready && !reset;
`else
  assign w_push         = 1'b0;
  assign w_pop          = 1'b0;
  assign w_skid_payload = '0;
  assign bus.mem_ready  = !reset && (!wb_valid_q || !bus.wb_stall);
`endif

  always_comb begin
    wb_valid_d   = wb_valid_q;
    wb_data_d    = wb_data_q;
    wb_retired_d = wb_retired_q;
    if (w_retire) begin
      wb_retired_d = wb_retired_q + CNT_W'(1);
    end
    if (reset) begin
      wb_valid_d   = 1'b0;
      wb_data_d    = '0;
      wb_retired_d = '0;
    end else if (bus.flush) begin
      wb_valid_d = 1'b0;
    end else if (w_pop) begin
      wb_valid_d = 1'b1;
      wb_data_d  = w_skid_payload;
    end else if (w_accept && !w_push) begin
      wb_valid_d = 1'b1;
      wb_data_d  = w_mem_payload;
    end else if (w_retire) begin
      // Data fields intentionally keep stale values.
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    wb_valid_q   <= wb_valid_d;
    wb_data_q    <= wb_data_d;
    wb_retired_q <= wb_retired_d;
  end

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_ReadData  = wb_data_q.read_data;
  assign bus.wb_AluResult = wb_data_q.alu_result;
  assign bus.wb_WriteReg  = wb_data_q.write_reg;
  assign bus.wb_RegWrite  = wb_data_q.reg_write && wb_valid_q;
  assign bus.wb_WriteData = wb_data_q.mem_to_reg ? wb_data_q.read_data
                                                 : wb_data_q.alu_result;
  assign bus.wb_retired   = wb_retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_pipe
// Description : Directed self-checking bench for mem_wb_pipe (CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_wb_pipe_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  mem_wb_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr, input logic rw, input logic m2r);
    bus.mem_valid     = v;
    bus.mem_ReadData  = rd;
    bus.mem_AluResult = alu;
    bus.mem_WriteReg  = wr;
    bus.mem_RegWrite  = rw;
    bus.mem_MemtoReg  = m2r;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.wb_valid); end
    checks++; if (bus.wb_retired !== 4'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", bus.wb_retired); end
    checks++; if (bus.wb_WriteData !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.wb_WriteData); end
    checks++; if (bus.wb_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", bus.wb_RegWrite); end
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_high: got %b want 0", bus.mem_ready); end
    reset = 1'b0;
    #1;
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", bus.mem_ready); end
  endtask

  task automatic test_streaming;
    logic [31:0] rd, alu;
    logic [4:0]  wr;
    logic        rw, m2r;
    for (int i = 0; i < 4; i++) begin
      rd = 32'hA000_0000 + 32'(i); alu = 32'h0000_0100 + 32'(i);
      wr = 5'(i + 1); rw = i[0]; m2r = i[1];
      drive(1'b1, rd, alu, wr, rw, m2r);
      tick();
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.wb_valid); end
      checks++; if (bus.wb_ReadData !== rd || bus.wb_AluResult !== alu || bus.wb_WriteReg !== wr)
        begin errors++; $display("FAIL stream_fields[%0d]: got %h/%h/%0d want %h/%h/%0d", i, bus.wb_ReadData, bus.wb_AluResult, bus.wb_WriteReg, rd, alu, wr); end
      checks++; if (bus.wb_RegWrite !== rw) begin errors++; $display("FAIL stream_regwrite[%0d]: got %b want %b", i, bus.wb_RegWrite, rw); end
      checks++; if (bus.wb_WriteData !== (m2r ? rd : alu)) begin errors++; $display("FAIL stream_wdata[%0d]: got %h want %h", i, bus.wb_WriteData, m2r ? rd : alu); end
      checks++; if (bus.wb_retired !== 4'(i)) begin errors++; $display("FAIL stream_retired[%0d]: got %0d want %0d", i, bus.wb_retired, i); end
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", bus.wb_valid); end
    checks++; if (bus.wb_RegWrite !== 1'b0) begin errors++; $display("FAIL stream_drain_regwrite: got %b want 0", bus.wb_RegWrite); end
    checks++; if (bus.wb_retired !== 4'd4) begin errors++; $display("FAIL stream_retired_total: got %0d want 4", bus.wb_retired); end
  endtask

  task automatic test_mux;
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd7, 1'b1, 1'b1);
    tick();
    checks++; if (bus.wb_WriteData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mux_readdata: got %h want deadbeef", bus.wb_WriteData); end
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd7, 1'b1, 1'b0);
    tick();
    checks++; if (bus.wb_WriteData !== 32'h0000_1234) begin errors++; $display("FAIL mux_aluresult: got %h want 00001234", bus.wb_WriteData); end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.wb_retired !== 4'd6) begin errors++; $display("FAIL mux_retired: got %0d want 6", bus.wb_retired); end
  endtask

  task automatic test_stall;
    drive(1'b1, 32'h1111_1111, 32'h0000_00AA, 5'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h2222_2222, 32'h0000_00BB, 5'd4, 1'b1, 1'b1);
    bus.wb_stall = 1'b1;
    #1;
`ifdef MEM_WB_SKID_EN
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_skid_empty: got %b want 1", bus.mem_ready); end
`else
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", bus.mem_ready); end
`endif
    for (int c = 0; c < 3; c++) begin
      tick();
`ifdef MEM_WB_SKID_EN
      bus.mem_valid = 1'b0;
`endif
      #1;
      checks++; if (bus.wb_valid !== 1'b1 || bus.wb_ReadData !== 32'h1111_1111 || bus.wb_WriteReg !== 5'd3)
        begin errors++; $display("FAIL stall_frozen[%0d]: got %b/%h/%0d want 1/11111111/3", c, bus.wb_valid, bus.wb_ReadData, bus.wb_WriteReg); end
      checks++; if (bus.wb_retired !== 4'd6) begin errors++; $display("FAIL stall_retired[%0d]: got %0d want 6", c, bus.wb_retired); end
      checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_held[%0d]: got %b want 0", c, bus.mem_ready); end
    end
    bus.wb_stall = 1'b0;
    tick();
    bus.mem_valid = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_ReadData !== 32'h2222_2222 || bus.wb_AluResult !== 32'h0000_00BB)
      begin errors++; $display("FAIL stall_release_second: got %b/%h/%h want 1/22222222/000000bb", bus.wb_valid, bus.wb_ReadData, bus.wb_AluResult); end
    checks++; if (bus.wb_retired !== 4'd7) begin errors++; $display("FAIL stall_release_retired: got %0d want 7", bus.wb_retired); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_retired !== 4'd8)
      begin errors++; $display("FAIL stall_drain: got %b/%0d want 0/8", bus.wb_valid, bus.wb_retired); end
  endtask

  task automatic test_flush;
    drive(1'b1, 32'h3333_3333, 32'h0000_00CC, 5'd9, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h4444_4444, 32'h0000_00DD, 5'd10, 1'b1, 1'b1);
    bus.flush = 1'b1;
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.flush = 1'b0;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.wb_valid); end
    checks++; if (bus.wb_RegWrite !== 1'b0) begin errors++; $display("FAIL flush_regwrite: got %b want 0", bus.wb_RegWrite); end
    checks++; if (bus.wb_retired !== 4'd8) begin errors++; $display("FAIL flush_retired: got %0d want 8", bus.wb_retired); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_retired !== 4'd8)
      begin errors++; $display("FAIL flush_after: got %b/%0d want 0/8", bus.wb_valid, bus.wb_retired); end
  endtask

  task automatic test_wrap;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'(i), 32'(i), 5'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    checks++; if (bus.wb_retired !== 4'd0) begin errors++; $display("FAIL wrap_16: got %0d want 0", bus.wb_retired); end
    tick();
    checks++; if (bus.wb_retired !== 4'd1) begin errors++; $display("FAIL wrap_17: got %0d want 1", bus.wb_retired); end
  endtask

  task automatic test_reset_mid_stall;
    drive(1'b1, 32'h5555_5555, 32'h0000_00EE, 5'd11, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h6666_6666, 32'h0000_00FF, 5'd12, 1'b1, 1'b1);
    bus.wb_stall = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_ready: got %b want 0", bus.mem_ready); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_RegWrite !== 1'b0 || bus.wb_retired !== 4'd0)
      begin errors++; $display("FAIL rst_stall_ctrl: got %b/%b/%0d want 0/0/0", bus.wb_valid, bus.wb_RegWrite, bus.wb_retired); end
    checks++; if (bus.wb_ReadData !== 32'h0 || bus.wb_AluResult !== 32'h0 || bus.wb_WriteReg !== 5'd0 || bus.wb_WriteData !== 32'h0)
      begin errors++; $display("FAIL rst_stall_data: got %h/%h/%0d/%h want all 0", bus.wb_ReadData, bus.wb_AluResult, bus.wb_WriteReg, bus.wb_WriteData); end
    reset = 1'b0;
    bus.wb_stall = 1'b0;
    #1;
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_ready_after: got %b want 1", bus.mem_ready); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_retired !== 4'd0)
      begin errors++; $display("FAIL rst_stall_no_ghost: got %b/%0d want 0/0", bus.wb_valid, bus.wb_retired); end
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.flush    = 1'b0;
    bus.wb_stall = 1'b0;
    test_reset();
    test_streaming();
    test_mux();
    test_stall();
    test_flush();
    test_wrap();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 The block SHALL have one clock, clk; reset, named reset, SHALL be synchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the datapath width of ReadData, AluResult and WriteData.
REQ-003 Parameter REG_W, default 5, SHALL set the destination register address width.
REQ-004 Parameter CNT_W, default 16, SHALL set the retire counter width.
REQ-005 The block SHALL have the following ports, each given as name, direction, width and meaning:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- mem_valid  in  1  MEM stage holds an instruction
- mem_ready  out  1  block accepts the MEM instruction this cycle
- mem_ReadData  in  DATA_W  load data
- mem_AluResult  in  DATA_W  ALU result
- mem_WriteReg  in  REG_W  destination register
- mem_RegWrite  in  1  instruction writes the register file
- mem_MemtoReg  in  1  1 selects ReadData, 0 selects AluResult
- flush  in  1  kill all held instructions
- wb_stall  in  1  WB cannot consume this cycle
- wb_valid  out  1  WB register holds a live instruction
- wb_ReadData, wb_AluResult  out  DATA_W  registered copies
- wb_WriteReg  out  REG_W  registered destination
- wb_RegWrite  out  1  registered RegWrite AND wb_valid
- wb_WriteData  out  DATA_W  wb_MemtoReg ? wb_ReadData : wb_AluResult (combinational from registers)
- wb_retired  out  CNT_W  count of retired instructions

Function
REQ-006 An accept SHALL occur when mem_valid and mem_ready are both 1; accepted fields SHALL appear on the wb_* outputs the next cycle (latency 1) when the output register is free.
REQ-007 A retire SHALL occur when wb_valid is 1, wb_stall is 0 and flush is 0.
REQ-008 Without skid, mem_ready SHALL equal (!wb_valid || !wb_stall) and SHALL be combinational.
REQ-009 While wb_valid is 1 and wb_stall is 1, all wb_* registers SHALL hold their values.
REQ-010 Accept and retire in the same cycle SHALL replace the output register contents with no bubble.
REQ-011 Retire without accept SHALL clear wb_valid next cycle; data registers SHALL keep their stale values.
REQ-012 flush SHALL clear wb_valid (and the skid entry) next cycle, has priority over accept, and SHALL drop any instruction accepted in that cycle.
REQ-013 wb_retired SHALL increment by 1 per retire and wrap from 2^CNT_W-1 to 0.
REQ-014 wb_RegWrite SHALL be 0 whenever wb_valid is 0.

Reset
REQ-015 In a cycle with reset high, next-cycle wb_valid, the skid entry, wb_retired and all wb_* data registers SHALL be 0; reset SHALL override flush and accept, and mem_ready SHALL be 0 while reset is high.
REQ-016 No output SHALL ever be driven to X.

Configuration
REQ-017 With macro MEM_WB_SKID_EN defined, a one-entry skid buffer SHALL be added and mem_ready SHALL be a register equal to "skid empty".
REQ-018 With MEM_WB_SKID_EN, an accept while the output is full and stalled SHALL fill the skid; when the stall releases, the skid SHALL move to the output register the next cycle, and only afterwards SHALL a new accept follow; order SHALL be preserved.
REQ-019 Without MEM_WB_SKID_EN, REQ-008 SHALL apply and no skid storage SHALL exist.

Structure
REQ-020 A shared package SHALL hold the struct for the MEM/WB payload (ReadData, AluResult, WriteReg, RegWrite, MemtoReg) and the default widths.
REQ-021 The skid buffer SHALL be a sub-module, pipe_skid, instantiated only under MEM_WB_SKID_EN.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Streaming: reset, then 4 back-to-back accepts with wb_stall=0 -> wb_valid stays 1 for 4 cycles, fields match with 1-cycle latency, wb_retired=4.
- Mux: mem_MemtoReg=1, ReadData=0xDEADBEEF, AluResult=0x1234 -> wb_WriteData=0xDEADBEEF; with MemtoReg=0 -> 0x00001234.
- Stall: wb_stall=1 for 3 cycles while full -> outputs frozen, wb_retired unchanged, mem_ready=0 (no skid) or 0 after one skid fill (skid); release -> both instructions retire in order.
- Flush with accept: flush=1 and accept in the same cycle -> wb_valid=0 next cycle, wb_RegWrite=0, no retire.
- Wrap: CNT_W=4, 17 retires -> wb_retired=1.
- Reset mid-stall: full output and skid, reset=1 -> all outputs 0 next cycle, mem_ready=1 the cycle after reset deasserts.
